// File: rtl/game_trace_recorder_pkg.sv
// Shared types and constants for the game trace recorder.
// Defining TRACE_TIMESTAMP_EN adds a timestamp field to every record.
package game_trace_recorder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECORD = 2'd1,
    ST_POST   = 2'd2,
    ST_DONE   = 2'd3
  } trace_state_e;

`ifdef TRACE_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  // Standard probe channel assignment used by game_control.
  localparam int unsigned CH_STATE     = 0;
  localparam int unsigned CH_CURR_IDX  = 1;
  localparam int unsigned CH_NEXT_IDX  = 2;
  localparam int unsigned CH_HOLD_IDX  = 3;
  localparam int unsigned CH_HOLD_USED = 4;
  localparam int unsigned CH_X         = 5;
  localparam int unsigned CH_Y         = 6;
  localparam int unsigned CH_ROT       = 7;

  function automatic int unsigned rec_width(input int unsigned num_ch,
                                            input int unsigned ch_w,
                                            input int unsigned ts_w);
    return num_ch + num_ch * ch_w + (TS_EN ? ts_w : 0);
  endfunction

endpackage

// File: rtl/game_trace_recorder_ring_mem.sv
// Ring buffer storage for trace records: pointers, occupancy and overflow.
// Full with push but no pop either overwrites the oldest entry (wrap) or drops.
module trace_ring_mem #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned W     = 54
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic                     wrap_mode,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          full;
  logic          pop;
  logic          push;
  logic          overwrite;

  always_comb begin
    full      = (count == FULL_CNT);
    rd_valid  = (count != '0);
    rd_data   = rd_valid ? mem[rptr] : '0;
    pop       = rd_valid & rd_ready;
    push      = wr_en & (~full | pop | wrap_mode);
    overwrite = wr_en & full & ~pop & wrap_mode;
    ovf       = wr_en & full & ~pop;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop || overwrite) rptr <= rptr + 1'b1;
      if (push && !pop && !overwrite) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_data;
  end

endmodule

// File: rtl/game_trace_recorder.sv
// Event trace recorder: stores a record whenever an unmasked probe channel changes.
// Defining TRACE_TIMESTAMP_EN prefixes each record with a saturating timestamp.
module game_trace_recorder
  import game_trace_recorder_pkg::*;
#(
  parameter int unsigned NUM_CH    = 6,
  parameter int unsigned CH_W      = 8,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned TS_W      = 16,
  parameter int unsigned POST_TRIG = 8
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [NUM_CH*CH_W-1:0]                   probe,
  input  logic [NUM_CH-1:0]                        ch_mask,
  input  logic                                     arm,
  input  logic                                     trigger,
  input  logic                                     wrap_mode,
  output logic                                     rd_valid,
  output logic [rec_width(NUM_CH, CH_W, TS_W)-1:0] rd_data,
  input  logic                                     rd_ready,
  output logic [1:0]                               state,
  output logic [$clog2(DEPTH):0]                   count,
  output logic                                     overflow,
  output logic                                     triggered
);
  localparam int unsigned PW    = NUM_CH * CH_W;
  localparam int unsigned REC_W = rec_width(NUM_CH, CH_W, TS_W);
  localparam int unsigned PC_W  = $clog2(POST_TRIG + 2);
  localparam logic [PC_W-1:0] POST_INIT = PC_W'(POST_TRIG);

  trace_state_e     st;
  trace_state_e     st_next;
  logic             first;
  logic [PW-1:0]    last;
  logic [PC_W-1:0]  post_cnt;
  logic [PC_W-1:0]  post_next;
  logic [NUM_CH-1:0] chg;
  logic [NUM_CH-1:0] rec_mask;
  logic             capture;
  logic             ev;
  logic             trig_set;
  logic             ovf;
  logic [REC_W-1:0] wr_data;

  assign state = st;

  always_comb begin
    chg = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      chg[k] = ch_mask[k] & (probe[k*CH_W +: CH_W] != last[k*CH_W +: CH_W]);
    end
    capture  = (st == ST_RECORD) || (st == ST_POST);
    rec_mask = first ? '1 : chg;
    ev       = capture & (first | (|chg));

    st_next   = st;
    post_next = post_cnt;
    trig_set  = 1'b0;
    case (st)
      ST_RECORD: begin
        if (trigger) begin
          trig_set = 1'b1;
          if (POST_TRIG == 0) begin
            st_next = ST_DONE;
          end else begin
            st_next   = ST_POST;
            post_next = POST_INIT;
          end
        end
      end
      ST_POST: begin
        if (ev) begin
          post_next = post_cnt - 1'b1;
          if (post_cnt == PC_W'(1)) st_next = ST_DONE;
        end
      end
      default: ;
    endcase
    if (arm) st_next = ST_RECORD;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st        <= ST_IDLE;
      first     <= 1'b0;
      last      <= '0;
      post_cnt  <= '0;
      overflow  <= 1'b0;
      triggered <= 1'b0;
    end else begin
      st       <= st_next;
      post_cnt <= post_next;
      last     <= probe;
      if (arm) begin
        first     <= 1'b1;
        overflow  <= 1'b0;
        triggered <= 1'b0;
      end else begin
        if (capture) first <= 1'b0;
        if (ovf) overflow <= 1'b1;
        if (trig_set) triggered <= 1'b1;
      end
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts;

  always_ff @(posedge clk) begin
    if (!rst_n || arm) ts <= '0;
    else if (capture && ts != '1) ts <= ts + 1'b1;
  end

  assign wr_data = {ts, rec_mask, probe};
`else
  assign wr_data = {rec_mask, probe};
`endif

  trace_ring_mem #(
    .DEPTH(DEPTH),
    .W    (REC_W)
  ) u_ring (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (arm),
    .wr_en    (ev),
    .wrap_mode(wrap_mode),
    .wr_data  (wr_data),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .count    (count),
    .ovf      (ovf)
  );

endmodule
